uart_cmd_parser: RTL and testbench

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_parser.sv | 132 +++++++++++++
 tb/tb_uart_cmd_parser.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// Byte-stream command parser: decodes SYNC/CMD/DATA/CHK frames from a UART receiver
// into register-file writes and chirp-start pulses, with XOR checksum and inter-byte timeout.
module uart_cmd_parser #(
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rx_valid,
  input  logic [7:0]            i_rx_data,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_start,
  output logic                  o_err,
  output logic                  o_busy,
  output logic [7:0]            o_err_cnt
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2,
    S_CHK  = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [7:0]              acc;
  logic [TW-1:0]           to_cnt;
  logic                    is_start;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    wr_c;
  logic                    start_c;
  logic                    err_c;
  logic                    timeout_c;

  assign timeout_c = (state != S_IDLE) && !i_rx_valid && (to_cnt == TO_LAST);

  // Next-state and pulse decode; a received byte always wins over a same-cycle timeout.
  always_comb begin
    state_nxt = state;
    wr_c      = 1'b0;
    start_c   = 1'b0;
    err_c     = 1'b0;
    if (i_rx_valid) begin
      case (state)
        S_IDLE: if (i_rx_data == SYNC_BYTE) state_nxt = S_CMD;
        S_CMD: begin
          case (i_rx_data[7:6])
            2'b00:   state_nxt = S_DATA;
            2'b01:   state_nxt = S_CHK;
            default: begin
              state_nxt = S_IDLE;
              err_c     = 1'b1;
            end
          endcase
        end
        S_DATA: state_nxt = S_CHK;
        S_CHK: begin
          state_nxt = S_IDLE;
          if (i_rx_data == acc) begin
            start_c = is_start;
            wr_c    = !is_start;
          end else begin
            err_c = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (timeout_c) begin
      state_nxt = S_IDLE;
      err_c     = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      to_cnt    <= '0;
      is_start  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_start   <= 1'b0;
      o_err     <= 1'b0;
      o_busy    <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      state   <= state_nxt;
      o_busy  <= (state_nxt != S_IDLE);
      o_wr_en <= wr_c;
      o_start <= start_c;
      o_err   <= err_c;

      if (err_c && (o_err_cnt != 8'hFF)) o_err_cnt <= o_err_cnt + 8'd1;

      if (i_rx_valid || (state == S_IDLE)) to_cnt <= '0;
      else                                 to_cnt <= to_cnt + TW'(1);

      // Checksum covers SYNC and every later byte of the frame.
      if (i_rx_valid) begin
        if (state == S_IDLE) begin
          if (i_rx_data == SYNC_BYTE) acc <= SYNC_BYTE;
        end else begin
          acc <= acc ^ i_rx_data;
        end
      end

      if (i_rx_valid && (state == S_CMD)) begin
        addr_q   <= ADDR_WIDTH'(i_rx_data[5:0]);
        is_start <= (i_rx_data[7:6] == 2'b01);
      end
      if (i_rx_valid && (state == S_DATA)) data_q <= DATA_WIDTH'(i_rx_data);

      if (wr_c) begin
        o_wr_addr <= addr_q;
        o_wr_data <= data_q;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: drivers queue expected pulses with their due cycle,
// a negedge monitor pops and compares whenever the DUT pulses an output.
module tb_uart_cmd_parser;

  localparam int unsigned TO = 16;
  localparam logic [2:0] K_WR  = 3'b001;
  localparam logic [2:0] K_ST  = 3'b010;
  localparam logic [2:0] K_ERR = 3'b100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic       err;
  logic       busy;
  logic [7:0] err_cnt;

  typedef struct {
    logic [2:0] kind;
    logic [5:0] addr;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   last_s = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  uart_cmd_parser #(
    .ADDR_WIDTH(6), .DATA_WIDTH(8), .TIMEOUT_CYCLES(TO), .SYNC_BYTE(8'hA5)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_start(start),
    .o_err(err), .o_busy(busy), .o_err_cnt(err_cnt)
  );

  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
  endtask

  // Called at a negedge; drives one byte for exactly one cycle.
  task automatic send(input logic [7:0] b, input logic [2:0] kind,
                      input logic [5:0] a, input logic [7:0] d);
    exp_t e;
    rx_valid = 1'b1;
    rx_data  = b;
    last_s   = cyc + 1;
    if (kind != 3'b000) begin
      e.kind = kind; e.addr = a; e.data = d; e.due = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every output pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (wr_en || start || err) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {29'd0, err, start, wr_en}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_kind", {29'd0, err, start, wr_en}, {29'd0, e.kind});
        chk("pulse_cycle", cyc, e.due);
        if (e.kind == K_WR) begin
          chk("wr_addr", {26'd0, wr_addr}, {26'd0, e.addr});
          chk("wr_data", {24'd0, wr_data}, {24'd0, e.data});
        end
      end
    end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
      chk("missing_pulse", 32'd0, {29'd0, exp_q[0].kind});
      void'(exp_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    chk("rst_wr_addr", {26'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Write frame
    send(8'hA5, 0, 0, 0);
    chk("busy_in_frame", {31'd0, busy}, 32'd1);
    send(8'h05, 0, 0, 0);
    send(8'h3C, 0, 0, 0);
    send(8'h9C, K_WR, 6'h05, 8'h3C);
    idle(2);
    chk("err_cnt_after_write", {24'd0, err_cnt}, 32'd0);
    chk("busy_after_write", {31'd0, busy}, 32'd0);

    // Start frame
    send(8'hA5, 0, 0, 0);
    send(8'h40, 0, 0, 0);
    send(8'hE5, K_ST, 0, 0);
    idle(2);

    // Bad checksum
    send(8'hA5, 0, 0, 0);
    send(8'h05, 0, 0, 0);
    send(8'h11, 0, 0, 0);
    send(8'h00, K_ERR, 0, 0);
    idle(2);
    chk("err_cnt_bad_chk", {24'd0, err_cnt}, 32'd1);
    chk("wr_addr_hold", {26'd0, wr_addr}, 32'h05);
    chk("wr_data_hold", {24'd0, wr_data}, 32'h3C);

    // Invalid opcode, then idle noise
    send(8'hA5, 0, 0, 0);
    send(8'hC0, K_ERR, 0, 0);
    idle(1);
    chk("busy_after_invalid", {31'd0, busy}, 32'd0);
    send(8'h00, 0, 0, 0);
    send(8'hFF, 0, 0, 0);
    idle(2);
    chk("busy_idle_noise", {31'd0, busy}, 32'd0);
    chk("err_cnt_invalid", {24'd0, err_cnt}, 32'd2);

    // Timeout after A5, 05
    send(8'hA5, 0, 0, 0);
    send(8'h05, 0, 0, 0);
    begin
      exp_t e;
      e.kind = K_ERR; e.addr = 0; e.data = 0; e.due = last_s + int'(TO);
      exp_q.push_back(e);
    end
    idle(TO + 3);
    chk("busy_after_timeout", {31'd0, busy}, 32'd0);
    chk("err_cnt_timeout", {24'd0, err_cnt}, 32'd3);

    // Byte lands on the last allowed cycle: accepted, frame completes
    send(8'hA5, 0, 0, 0);
    send(8'h07, 0, 0, 0);
    idle(TO - 1);
    send(8'h5A, 0, 0, 0);
    idle(TO - 1);
    send(8'hF8, K_WR, 6'h07, 8'h5A);
    idle(2);
    chk("err_cnt_boundary", {24'd0, err_cnt}, 32'd3);

    // Reset mid-frame abandons it and clears state
    send(8'hA5, 0, 0, 0);
    send(8'h05, 0, 0, 0);
    send(8'h3C, 0, 0, 0);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    chk("busy_after_rst", {31'd0, busy}, 32'd0);
    chk("err_cnt_after_rst", {24'd0, err_cnt}, 32'd0);
    chk("wr_addr_after_rst", {26'd0, wr_addr}, 32'd0);
    send(8'h9C, 0, 0, 0);
    idle(2);
    send(8'hA5, 0, 0, 0);
    send(8'h2A, 0, 0, 0);
    send(8'h81, 0, 0, 0);
    send(8'h0E, K_WR, 6'h2A, 8'h81);
    idle(2);

    // Saturation over 300 error frames
    for (int i = 0; i < 300; i++) begin
      send(8'hA5, 0, 0, 0);
      send(8'hC0, K_ERR, 0, 0);
    end
    idle(2);
    chk("err_cnt_saturated", {24'd0, err_cnt}, 32'd255);

    // SYNC value seen as CMD has opcode 10: error, not a resync
    send(8'hA5, 0, 0, 0);
    send(8'hA5, K_ERR, 0, 0);
    send(8'h40, 0, 0, 0);
    send(8'hE5, 0, 0, 0);
    idle(2);
    chk("busy_after_sync_cmd", {31'd0, busy}, 32'd0);
    chk("err_cnt_stays_255", {24'd0, err_cnt}, 32'd255);

    idle(3);
    chk("pending_expectations", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
